acl2_ctrl: RTL

ACL2_CTRL -- requirements
Module: acl2_ctrl

---
 rtl/acl2_ctrl_if.sv | 25 ++
 rtl/acl2_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/acl2_ctrl_if.sv
// SPI byte-engine link between the ACL2 controller and the byte shifter.
//   begin_transmission : controller -> engine, held high for a whole multi-byte transaction
//   send_data          : controller -> engine, byte to shift out next
//   end_transmission   : engine -> controller, one-cycle pulse per completed byte
//   recieved_data      : engine -> controller, byte shifted in, valid with end_transmission
interface acl2_ctrl_if;
    logic       begin_transmission;
    logic [7:0] send_data;
    logic       end_transmission;
    logic [7:0] recieved_data;

    modport master (
        output begin_transmission,
        output send_data,
        input  end_transmission,
        input  recieved_data
    );

    modport slave (
        input  begin_transmission,
        input  send_data,
        output end_transmission,
        output recieved_data
    );
endinterface

// File: rtl/acl2_ctrl.sv
// ACL2 accelerometer controller: configures the sensor (FILTER_CTL, POWER_CTL) after a
// power-up delay, then periodically burst-reads X/Y/Z and publishes 12-bit samples.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_enable      : permits periodic reads (sampled only while waiting)
//   spi_bus       : byte-engine link (master side)
//   o_accel_x/y/z : latest two's-complement samples
//   o_data_valid  : one-cycle pulse when o_accel_* update
//   o_init_done   : both configuration writes complete
//   o_busy        : transaction in flight or inter-transaction gap
module acl2_ctrl #(
    parameter logic [23:0] STARTUP_CYCLES = 24'd5_000_000,
    parameter logic [23:0] SAMPLE_PERIOD  = 24'd1_000_000,
    parameter logic [23:0] GAP_CYCLES     = 24'd10_000,
    parameter logic [7:0]  FILTER_CTL_VAL = 8'h13,
    parameter logic [7:0]  POWER_CTL_VAL  = 8'h02
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    acl2_ctrl_if.master spi_bus,
    output logic [11:0] o_accel_x,
    output logic [11:0] o_accel_y,
    output logic [11:0] o_accel_z,
    output logic        o_data_valid,
    output logic        o_init_done,
    output logic        o_busy
);

    typedef enum logic [3:0] {
        StStartup, StCfgFilter, StGap1, StCfgPower, StGap2, StWait, StRead, StGap3, StPublish
    } state_e;

    state_e      r_state;
    logic [23:0] r_cnt;
    logic [2:0]  r_byte_cnt;
    logic        r_first_wait;
    logic        r_begin;
    logic [7:0]  r_send;
    logic [7:0]  r_xl, r_xh, r_yl, r_yh, r_zl, r_zh;
    logic [11:0] r_accel_x, r_accel_y, r_accel_z;
    logic        r_dv, r_init_done, r_busy;

    logic [23:0] w_limit;
    logic        w_cnt_term;
    logic [23:0] w_cnt_sat;
    logic [2:0]  w_next_idx;
    logic [7:0]  w_next_byte;
    logic        w_last_byte;
    logic        w_et;
    logic [7:0]  w_rd;

    assign w_et = spi_bus.end_transmission;
    assign w_rd = spi_bus.recieved_data;

    always_comb begin
        w_limit = GAP_CYCLES;
        case (r_state)
            StStartup: w_limit = STARTUP_CYCLES;
            StWait:    w_limit = SAMPLE_PERIOD;
            default:   w_limit = GAP_CYCLES;
        endcase
    end

    // Terminal when this cycle completes the required count; the count then holds (no wrap).
    assign w_cnt_term = ({1'b0, r_cnt} + 25'd1) >= {1'b0, w_limit};
    assign w_cnt_sat  = w_cnt_term ? r_cnt : r_cnt + 24'd1;

    assign w_next_idx  = r_byte_cnt + 3'd1;
    assign w_last_byte = (r_state == StRead) ? (r_byte_cnt == 3'd7) : (r_byte_cnt == 3'd2);

    always_comb begin
        w_next_byte = 8'h00;
        case (r_state)
            StCfgFilter: w_next_byte = (w_next_idx == 3'd1) ? 8'h2C : FILTER_CTL_VAL;
            StCfgPower:  w_next_byte = (w_next_idx == 3'd1) ? 8'h2D : POWER_CTL_VAL;
            StRead:      w_next_byte = (w_next_idx == 3'd1) ? 8'h0E : 8'h00;
            default:     w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StStartup;
            r_cnt        <= 24'd0;
            r_byte_cnt   <= 3'd0;
            r_first_wait <= 1'b0;
            r_begin      <= 1'b0;
            r_send       <= 8'h00;
            r_xl         <= 8'h00;
            r_xh         <= 8'h00;
            r_yl         <= 8'h00;
            r_yh         <= 8'h00;
            r_zl         <= 8'h00;
            r_zh         <= 8'h00;
            r_accel_x    <= 12'h000;
            r_accel_y    <= 12'h000;
            r_accel_z    <= 12'h000;
            r_dv         <= 1'b0;
            r_init_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                StStartup, StGap1: begin
                    if (w_cnt_term) begin
                        r_state    <= (r_state == StStartup) ? StCfgFilter : StCfgPower;
                        r_cnt      <= 24'd0;
                        r_begin    <= 1'b1;
                        r_send     <= 8'h0A;
                        r_byte_cnt <= 3'd0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_sat;
                    end
                end
                StCfgFilter, StCfgPower, StRead: begin
                    if (w_et) begin
                        if (r_state == StRead) begin
                            case (r_byte_cnt)
                                3'd2:    r_xl <= w_rd;
                                3'd3:    r_xh <= w_rd;
                                3'd4:    r_yl <= w_rd;
                                3'd5:    r_yh <= w_rd;
                                3'd6:    r_zl <= w_rd;
                                3'd7:    r_zh <= w_rd;
                                default: ;
                            endcase
                        end
                        if (w_last_byte) begin
                            r_begin <= 1'b0;
                            r_cnt   <= 24'd0;
                            r_state <= (r_state == StCfgFilter) ? StGap1 :
                                       (r_state == StCfgPower)  ? StGap2 : StGap3;
                        end else begin
                            r_send     <= w_next_byte;
                            r_byte_cnt <= w_next_idx;
                        end
                    end
                end
                StGap2: begin
                    if (w_cnt_term) begin
                        r_state      <= StWait;
                        r_cnt        <= 24'd0;
                        r_init_done  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_first_wait <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_sat;
                    end
                end
                StGap3: begin
                    if (w_cnt_term) begin
                        // Outputs change only here, so a partial read never escapes.
                        r_state   <= StPublish;
                        r_cnt     <= 24'd0;
                        r_accel_x <= {r_xh[3:0], r_xl};
                        r_accel_y <= {r_yh[3:0], r_yl};
                        r_accel_z <= {r_zh[3:0], r_zl};
                        r_dv      <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_sat;
                    end
                end
                StPublish: begin
                    r_state <= StWait;
                    r_cnt   <= 24'd0;
                end
                StWait: begin
                    // First wait after init is zero-length.
                    if ((r_first_wait || w_cnt_term) && i_enable) begin
                        r_state      <= StRead;
                        r_cnt        <= 24'd0;
                        r_begin      <= 1'b1;
                        r_send       <= 8'h0B;
                        r_byte_cnt   <= 3'd0;
                        r_busy       <= 1'b1;
                        r_first_wait <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_sat;
                    end
                end
                default: begin
                    r_state <= StStartup;
                    r_cnt   <= 24'd0;
                end
            endcase
        end
    end

    assign spi_bus.begin_transmission = r_begin;
    assign spi_bus.send_data          = r_send;
    assign o_accel_x                  = r_accel_x;
    assign o_accel_y                  = r_accel_y;
    assign o_accel_z                  = r_accel_z;
    assign o_data_valid               = r_dv;
    assign o_init_done                = r_init_done;
    assign o_busy                     = r_busy;

endmodule
